// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared types and helpers for the frame-buffer write path.
//   fb_state_t   : draw-pass sequencer states
//   DEF_*        : default frame geometry and colour depth
//   xy_to_addr() : linear pixel address y*width + x, built as a constant
//                  shift-add so no hardware multiplier is inferred
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_ACTIVE,
        ST_STREAM,
        ST_NEXT,
        ST_SWAP
    } fb_state_t;

    localparam int DEF_DRAW_WIDTH  = 640;
    localparam int DEF_DRAW_HEIGHT = 480;
    localparam int DEF_COLOR_DEPTH = 9;

    // width is always an elaboration-time constant, so only the set bits of
    // width turn into adders of a shifted copy of y.
    function automatic logic [31:0] xy_to_addr(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input int          width);
        logic [31:0] acc;
        acc = x;
        for (int i = 0; i < 32; i++) begin
            if (width[i]) begin
                acc = acc + (y << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Registered pixel-to-memory stage. A pixel accepted in one cycle becomes a
// single-cycle frame-buffer write in the next; off-screen pixels are dropped.
//   clk, resetN  : clock, asynchronous active-low reset
//   pix_valid    : a pixel is present on pix_x/pix_y/pix_color this cycle
//   pix_x, pix_y : pixel column / row from the write bus
//   pix_color    : pixel colour
//   mem_we       : write strobe (one cycle after the accepted pixel)
//   mem_addr     : linear address y*DRAW_WIDTH + x, truncated to ADDR_WIDTH
//   mem_wdata    : colour being written
// -----------------------------------------------------------------------------
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int DRAW_WIDTH  = DEF_DRAW_WIDTH,
    parameter int DRAW_HEIGHT = DEF_DRAW_HEIGHT,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   pix_valid,
    input  logic [31:0]            pix_x,
    input  logic [31:0]            pix_y,
    input  logic [COLOR_DEPTH-1:0] pix_color,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [COLOR_DEPTH-1:0] mem_wdata
);

    logic in_bounds;
    logic do_write;

    // Unsigned compare: a "negative" coordinate wraps huge and is rejected too.
    assign in_bounds = (pix_x < 32'(DRAW_WIDTH)) && (pix_y < 32'(DRAW_HEIGHT));
    assign do_write  = pix_valid && in_bounds;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr  <= ADDR_WIDTH'(xy_to_addr(pix_x, pix_y, DRAW_WIDTH));
                mem_wdata <= pix_color;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Sink end of the shared pixel-write bus. On each frame_start it grants the
// bus to draw sources 0..NUM_SOURCES-1 in turn, turns streamed pixels into
// back-buffer writes, then swaps front/back buffers and pulses frame_done.
//   clk, resetN        : clock, asynchronous active-low reset
//   frame_start        : one-cycle pulse starting a draw pass
//   write_source_sel   : ID of the source owning the bus
//   write_awaited      : grant to the selected source
//   write_active       : selected source is streaming pixels
//   write_color_data   : pixel colour      (ignored while write_active=0)
//   write_x_addr/y_addr: pixel coordinates (ignored while write_active=0)
//   mem_we/addr/wdata  : single-cycle frame-buffer write
//   mem_bank           : bank being written (always the back buffer)
//   buf_sel            : bank being displayed (front buffer)
//   busy               : draw pass in progress
//   frame_done         : one-cycle pulse after the buffer swap
//   err_timeout        : sticky, a granted source never went active
//   err_overrun        : sticky, frame_start arrived during a pass
// -----------------------------------------------------------------------------
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_SOURCES   = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int COLOR_DEPTH   = DEF_COLOR_DEPTH,
    parameter int DRAW_WIDTH    = DEF_DRAW_WIDTH,
    parameter int DRAW_HEIGHT   = DEF_DRAW_HEIGHT,
    parameter int ADDR_WIDTH    = 19,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame_start,
    output logic [SEL_WIDTH-1:0]   write_source_sel,
    output logic                   write_awaited,
    input  logic                   write_active,
    input  logic [COLOR_DEPTH-1:0] write_color_data,
    input  logic [31:0]            write_x_addr,
    input  logic [31:0]            write_y_addr,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_bank,
    output logic [COLOR_DEPTH-1:0] mem_wdata,
    output logic                   buf_sel,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_timeout,
    output logic                   err_overrun
);

    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [SEL_WIDTH-1:0] LAST_SRC = SEL_WIDTH'(NUM_SOURCES - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    fb_state_t            state_q, state_d;
    logic [SEL_WIDTH-1:0] index_q, index_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 awaited_q, awaited_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 buf_sel_q, buf_sel_d;
    logic                 bank_q, bank_d;
    logic                 err_to_q, err_to_d;
    logic                 err_ov_q, err_ov_d;
    logic                 pix_valid;

    // A source may present its first pixel on the very cycle it raises
    // write_active, which is still WAIT_ACTIVE here.
    assign pix_valid = write_active &&
                       ((state_q == ST_WAIT_ACTIVE) || (state_q == ST_STREAM));

    // NOTE: every signal assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        awaited_d = awaited_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        buf_sel_d = buf_sel_q;
        bank_d    = bank_q;
        err_to_d  = err_to_q;
        err_ov_d  = err_ov_q | (frame_start && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_GRANT;
                    index_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                awaited_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                // Grant must drop on the accept edge, before the source
                // finishes and looks at write_awaited again.
                if (write_active) begin
                    awaited_d = 1'b0;
                    state_d   = ST_STREAM;
                end else if (cnt_q == CNT_LAST) begin
                    awaited_d = 1'b0;
                    err_to_d  = 1'b1;
                    state_d   = ST_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STREAM: begin
                if (!write_active) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (index_q == LAST_SRC) begin
                    // Wrap the selection here so it is already 0 for the
                    // next frame; outputs seen during SWAP are set on this edge.
                    index_d   = '0;
                    buf_sel_d = ~buf_sel_q;
                    bank_d    = buf_sel_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_SWAP;
                end else begin
                    index_d = index_q + SEL_WIDTH'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            cnt_q     <= '0;
            awaited_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            buf_sel_q <= 1'b0;
            bank_q    <= 1'b1;
            err_to_q  <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            awaited_q <= awaited_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            buf_sel_q <= buf_sel_d;
            bank_q    <= bank_d;
            err_to_q  <= err_to_d;
            err_ov_q  <= err_ov_d;
        end
    end

    assign write_source_sel = index_q;
    assign write_awaited    = awaited_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign buf_sel          = buf_sel_q;
    assign mem_bank         = bank_q;
    assign err_timeout      = err_to_q;
    assign err_overrun      = err_ov_q;

    fb_addr_gen #(
        .COLOR_DEPTH (COLOR_DEPTH),
        .DRAW_WIDTH  (DRAW_WIDTH),
        .DRAW_HEIGHT (DRAW_HEIGHT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .resetN    (resetN),
        .pix_valid (pix_valid),
        .pix_x     (write_x_addr),
        .pix_y     (write_y_addr),
        .pix_color (write_color_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Stub draw sources drive the write bus; a reference model derives, from the
// pixel lists alone, the ordered list of expected writes, the final picture
// of each frame and the frame-completion status. A monitor compares every
// write strobe and frame_done pulse against the expectation queues.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NS   = 2;
    localparam int SW   = 1;
    localparam int CD   = 9;
    localparam int AW   = 3;
    localparam int TO   = 16;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          frame_start = 1'b0;
    logic [SW-1:0] write_source_sel;
    logic          write_awaited;
    logic          write_active = 1'b0;
    logic [CD-1:0] write_color_data = '0;
    logic [31:0]   write_x_addr = '0;
    logic [31:0]   write_y_addr = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_bank;
    logic [CD-1:0] mem_wdata;
    logic          buf_sel;
    logic          busy;
    logic          frame_done;
    logic          err_timeout;
    logic          err_overrun;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .NUM_SOURCES   (NS),
        .SEL_WIDTH     (SW),
        .COLOR_DEPTH   (CD),
        .DRAW_WIDTH    (W),
        .DRAW_HEIGHT   (H),
        .ADDR_WIDTH    (AW),
        .GRANT_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .frame_start      (frame_start),
        .write_source_sel (write_source_sel),
        .write_awaited    (write_awaited),
        .write_active     (write_active),
        .write_color_data (write_color_data),
        .write_x_addr     (write_x_addr),
        .write_y_addr     (write_y_addr),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_bank         (mem_bank),
        .mem_wdata        (mem_wdata),
        .buf_sel          (buf_sel),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_timeout      (err_timeout),
        .err_overrun      (err_overrun)
    );

    typedef struct { int x; int y; int c; }          pix_t;
    typedef struct { int addr; int data; int bank; } wr_t;
    typedef struct { int front; int to; int ov; }    done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    pix_t  src_pix[NS][$];
    bit    src_resp[NS];
    int    shadow[2][NPIX];
    int    model_img[NPIX];
    int    model_front = 0;
    bit    model_to = 1'b0;
    bit    model_ov = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe and frame_done pulse consumes one expectation.
    initial begin
        wr_t   ew;
        done_t ed;
        forever begin
            @(negedge clk);
            if (resetN) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("wr_addr", 32'(mem_addr), ew.addr);
                        check("wr_data", 32'(mem_wdata), ew.data);
                        check("wr_bank", 32'(mem_bank), ew.bank);
                    end
                    shadow[mem_bank][mem_addr] = int'(mem_wdata);
                end
                if (frame_done) begin
                    if (exp_done.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame_done: pulse seen, none expected");
                    end else begin
                        ed = exp_done.pop_front();
                        check("done_buf_sel", 32'(buf_sel), ed.front);
                        check("done_mem_bank", 32'(mem_bank), 1 - ed.front);
                        check("done_busy_low", 32'(busy), 0);
                        check("done_err_timeout", 32'(err_timeout), ed.to);
                        check("done_err_overrun", 32'(err_overrun), ed.ov);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_sources();
        for (int s = 0; s < NS; s++) begin
            src_pix[s].delete();
            src_resp[s] = 1'b1;
        end
    endtask

    task automatic add_pix(input int s, input int x, input int y, input int c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        src_pix[s].push_back(p);
    endtask

    task automatic drive_garbage();
        write_active     = 1'b0;
        write_x_addr     = $urandom;
        write_y_addr     = $urandom;
        write_color_data = CD'($urandom);
    endtask

    task automatic reset_midstream();
        resetN = 1'b0;
        #1;
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_awaited", 32'(write_awaited), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_buf_sel", 32'(buf_sel), 0);
        check("rst_sel", 32'(write_source_sel), 0);
        check("rst_mem_bank", 32'(mem_bank), 1);
        check("rst_err_overrun", 32'(err_overrun), 0);
        drive_garbage();
        exp_wr.delete();
        model_front = 0;
        model_to    = 1'b0;
        model_ov    = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    // overrun_at / reset_at: pixel index of source 0 at which to pulse
    // frame_start / assert reset (-1 = never).
    task automatic run_frame(input int overrun_at, input int reset_at);
        int back;
        int cnt;
        pix_t p;
        back = 1 - model_front;
        for (int a = 0; a < NPIX; a++) begin
            shadow[back][a] = -1;
            model_img[a]    = -1;
        end
        // Reference: sources write in ID order, each in list order; later
        // in-bounds pixels overwrite earlier ones.
        for (int s = 0; s < NS; s++) begin
            if (!src_resp[s]) model_to = 1'b1;
            for (int k = 0; k < src_pix[s].size(); k++) begin
                p = src_pix[s][k];
                if (src_resp[s] && p.x < W && p.y < H) begin
                    model_img[p.y * W + p.x] = p.c;
                    exp_wr.push_back('{p.y * W + p.x, p.c, back});
                end
            end
        end
        if (overrun_at >= 0) model_ov = 1'b1;
        if (reset_at < 0) exp_done.push_back('{1 - model_front, int'(model_to), int'(model_ov)});

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_awaited_low", 32'(write_awaited), 0);

        for (int s = 0; s < NS; s++) begin
            cnt = 0;
            while (!write_awaited && cnt < 64) begin
                @(negedge clk);
                cnt++;
            end
            if (!write_awaited) begin
                n_cmp++;
                n_err++;
                $display("FAIL grant_wait: source %0d never granted", s);
                return;
            end
            if (s == 0) check("first_grant_latency", cnt, 1);
            check("grant_sel", 32'(write_source_sel), s);
            if (src_resp[s]) begin
                for (int k = 0; k < src_pix[s].size(); k++) begin
                    if (s == 0 && k == reset_at) begin
                        #2;
                        reset_midstream();
                        return;
                    end
                    p = src_pix[s][k];
                    write_active     = 1'b1;
                    write_x_addr     = p.x;
                    write_y_addr     = p.y;
                    write_color_data = CD'(p.c);
                    frame_start      = (s == 0 && k == overrun_at);
                    @(negedge clk);
                    frame_start = 1'b0;
                    if (k == 0) check("awaited_cleared", 32'(write_awaited), 0);
                end
                drive_garbage();
            end else begin
                cnt = 0;
                while (write_awaited && cnt < 40) begin
                    cnt++;
                    @(negedge clk);
                end
                check("timeout_cycles", cnt, TO);
                check("err_timeout_set", 32'(err_timeout), 1);
            end
        end

        cnt = 0;
        while (!frame_done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("frame_done_seen", 32'(frame_done), 1);
        for (int a = 0; a < NPIX; a++) begin
            check("image", shadow[back][a], model_img[a]);
        end
        model_front = 1 - model_front;
        @(negedge clk);
        check("frame_done_one_cycle", 32'(frame_done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        drive_garbage();
        repeat (3) @(negedge clk);
        check("reset_awaited", 32'(write_awaited), 0);
        check("reset_sel", 32'(write_source_sel), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        check("reset_mem_addr", 32'(mem_addr), 0);
        check("reset_mem_wdata", 32'(mem_wdata), 0);
        check("reset_buf_sel", 32'(buf_sel), 0);
        check("reset_mem_bank", 32'(mem_bank), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_err_timeout", 32'(err_timeout), 0);
        check("reset_err_overrun", 32'(err_overrun), 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Source 0 fills the screen, source 1 overwrites one pixel.
        clear_sources();
        for (int i = 0; i < NPIX; i++) add_pix(0, i % W, i / W, 'h092);
        add_pix(1, 2, 1, 'h1FF);
        run_frame(-1, -1);

        // Source 1 never answers its grant.
        clear_sources();
        add_pix(0, 1, 0, 'h055);
        add_pix(0, 3, 1, 'h100);
        src_resp[1] = 1'b0;
        run_frame(-1, -1);

        // Off-screen pixels are dropped.
        clear_sources();
        add_pix(0, 0, 0, 'h0A1);
        add_pix(0, 4, 0, 'h0AA);
        add_pix(0, 1, 1, 'h0BB);
        add_pix(0, 0, 2, 'h0CC);
        add_pix(0, 3, 1, 'h0DD);
        add_pix(1, 2, 0, 'h011);
        run_frame(-1, -1);

        // frame_start during streaming: flagged, frame unaffected.
        clear_sources();
        for (int i = 0; i < 6; i++) add_pix(0, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 511));
        add_pix(1, 3, 0, 'h123);
        run_frame(2, -1);
        repeat (30) @(negedge clk);
        check("overrun_no_restart_busy", 32'(busy), 0);

        // Reset in the middle of source 0's stream.
        clear_sources();
        for (int i = 0; i < 6; i++) add_pix(0, i % W, i / W, 'h040 + i);
        add_pix(1, 0, 0, 'h1AB);
        run_frame(-1, 3);

        // Randomised frames.
        for (int f = 0; f < 12; f++) begin
            clear_sources();
            for (int s = 0; s < NS; s++) begin
                src_resp[s] = ($urandom_range(0, 4) != 0);
                for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                    add_pix(s, $urandom_range(0, W), $urandom_range(0, H), $urandom_range(0, 511));
                end
            end
            run_frame(-1, -1);
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("writes_drained", exp_wr.size(), 0);
        check("frames_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sink/master end of the shared pixel-write bus that background and sprite draw sources drive.
- Per frame, grants the bus to each draw source in turn: drives write_source_sel, pulses write_awaited, and consumes write_active/color/x/y.
- Converts each pixel to a linear frame-buffer address and issues single-cycle writes into the back buffer.
- After the last source completes, swaps front/back buffers and reports frame completion.

Parameters:
- NUM_SOURCES, 4, number of draw sources; sources are selected as IDs 0..NUM_SOURCES-1, in ascending order (0 = background, drawn first).
- SEL_WIDTH, 2, width of write_source_sel.
- COLOR_DEPTH, 9, pixel colour width.
- DRAW_WIDTH, 640, frame width in pixels.
- DRAW_HEIGHT, 480, frame height in pixels.
- ADDR_WIDTH, 19, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= DRAW_WIDTH*DRAW_HEIGHT.
- GRANT_TIMEOUT, 16, cycles to wait for write_active after a grant before skipping the source.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse (vsync-derived) that starts a frame's draw pass
- write_source_sel  out  SEL_WIDTH  ID of the source currently owning the bus
- write_awaited  out  1  grant/request to the selected source
- write_active  in  1  selected source is streaming pixels
- write_color_data  in  COLOR_DEPTH  pixel colour
- write_x_addr  in  32  pixel column
- write_y_addr  in  32  pixel row
- mem_we  out  1  frame-buffer write strobe
- mem_addr  out  ADDR_WIDTH  {linear address}; buffer bank selected by mem_bank
- mem_bank  out  1  back-buffer bank being written (= ~buf_sel)
- mem_wdata  out  COLOR_DEPTH  write data
- buf_sel  out  1  front (display) buffer bank
- busy  out  1  draw pass in progress
- frame_done  out  1  one-cycle pulse after the buffer swap
- err_timeout  out  1  sticky; a granted source never went active
- err_overrun  out  1  sticky; frame_start arrived while busy

Behaviour:
- Reset (resetN low, asynchronous, any state): state IDLE, source index 0, write_source_sel=0, write_awaited=0, mem_we=0, mem_addr=0, mem_wdata=0, buf_sel=0, mem_bank=1, busy=0, frame_done=0, err_*=0. All outputs are registered.
- IDLE:
  - frame_start=1 -> GRANT with index=0 and busy=1.
- GRANT (1 cycle):
  - write_source_sel=index.
  - write_awaited set to 1 the next cycle.
  - Timeout counter cleared.
  - -> WAIT_ACTIVE.
- WAIT_ACTIVE:
  - write_awaited held at 1.
  - write_active=1 -> STREAM, with write_awaited cleared on the same edge. It must be low before the source returns to its await state, or the source restarts.
  - Counter reaching GRANT_TIMEOUT -> set err_timeout, clear write_awaited, -> NEXT.
- STREAM:
  - Every cycle with write_active=1, the input pixel is registered.
  - The next cycle has mem_we=1, mem_addr=y*DRAW_WIDTH+x, mem_wdata=colour (write latency 1 cycle).
  - If x>=DRAW_WIDTH or y>=DRAW_HEIGHT, the write is suppressed (mem_we=0).
  - The multiply uses constant shift-add; the result is truncated to ADDR_WIDTH.
  - Bus inputs are ignored whenever write_active=0, since they may be high-Z.
  - write_active=0 -> NEXT. The final pending write still issues on that cycle.
- NEXT (1 cycle):
  - index==NUM_SOURCES-1 -> SWAP.
  - Otherwise index+1 -> GRANT. write_source_sel changes only here or at reset.
- SWAP (1 cycle):
  - buf_sel toggles (mem_bank follows).
  - frame_done=1 for exactly this cycle.
  - busy=0.
  - -> IDLE.
- frame_start while not IDLE: ignored, err_overrun set.
- frame_start in IDLE on the same cycle as a SWAP exit cannot occur (SWAP is not IDLE), so the pulse counts as overrun.
- Later pixels overwrite earlier ones at the same address. Ascending source order gives higher IDs priority.
- Reset mid-STREAM abandons the frame. The buffer is not swapped.

Decomposition:
- Shared package fb_pkg holds:
  - state enum (IDLE, GRANT, WAIT_ACTIVE, STREAM, NEXT, SWAP)
  - DRAW_WIDTH/DRAW_HEIGHT defaults
  - COLOR_DEPTH default
  - function xy_to_addr
- One natural sub-module: fb_addr_gen, a registered stage implementing bounds check, y*W+x and write-strobe generation.

Test Plan (bench uses stub sources with the same handshake, run at DRAW_WIDTH=4, DRAW_HEIGHT=2, NUM_SOURCES=2):
1. Reset, then frame_start pulse -> sel=0, awaited=1 two cycles later. Source 0 streams 8 pixels of colour 0x092 -> 8 mem_we pulses, addr 0..7, each one cycle after its pixel, mem_bank=1.
2. Full frame: source 1 draws colour 0x1FF at (2,1) only -> final write addr 6 data 0x1FF after source 0's writes. Then buf_sel 0->1 and a frame_done 1-cycle pulse, busy falls the same cycle.
3. Source 1 never responds -> err_timeout=1 after 16 cycles in WAIT_ACTIVE, awaited=0, swap still occurs, frame_done pulses.
4. Source drives x=4,y=0 and x=0,y=2 while active -> no mem_we for those cycles, other pixels written normally.
5. frame_start pulsed during STREAM -> err_overrun=1, current frame continues unaffected, exactly one frame_done.
6. resetN low mid-STREAM -> mem_we, write_awaited, busy immediately 0, buf_sel=0, sel=0. The next frame_start restarts from source 0.
